// File: rtl/endpoint_tx_host_if.sv
// endpoint_tx_host_if
// Groups the command, payload stream, bus-initiator and status signals of
// endpoint_tx_host. The "slave" modport is the endpoint's view (it accepts
// commands and data, and it drives the bus and status). The "master" modport
// is the host/environment view (it issues commands, supplies data and
// responds on the bus).
//   cmd_*      : send command (valid/ready handshake)
//   data_*     : payload word stream (valid/ready handshake)
//   bus_*      : single-beat write bus driven by the endpoint, with stall/error
//   busy/done/err : status; done and err are one-cycle pulses
interface endpoint_tx_host_if #(
  parameter int NUM_MSGS        = 4,
  parameter int CACHE_NUM_WORDS = 128
);
  localparam int MSG_W  = $clog2(NUM_MSGS);
  localparam int WORD_W = $clog2(CACHE_NUM_WORDS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [MSG_W-1:0]  cmd_msg_id;
  logic [WORD_W-1:0] cmd_start_word;
  logic [WORD_W:0]   cmd_len;

  logic              data_valid;
  logic              data_ready;
  logic [31:0]       data_word;

  logic              bus_wen;
  logic              bus_ren;
  logic [31:0]       bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_strobe;
  logic [31:0]       bus_rdata;
  logic              bus_error;
  logic              bus_request_stall;

  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_msg_id, cmd_start_word, cmd_len,
    input  data_valid, data_word,
    input  bus_rdata, bus_error, bus_request_stall,
    output cmd_ready, data_ready,
    output bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe,
    output busy, done, err
  );

  modport master (
    output cmd_valid, cmd_msg_id, cmd_start_word, cmd_len,
    output data_valid, data_word,
    output bus_rdata, bus_error, bus_request_stall,
    input  cmd_ready, data_ready,
    input  bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe,
    input  busy, done, err
  );
endinterface

// File: rtl/endpoint_tx_host.sv
// endpoint_tx_host
// Takes a send command (message slot, start word, length), streams the payload
// words into the TX cache window at 0x2000 (wrapping inside the cache), then
// writes the message pointer (4*msg_id <- 4*start_word) and finally kicks the
// send register (0x1004 <- msg_id). Any bus error aborts the command.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   io   : endpoint_tx_host_if.slave (command, payload, bus, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// WR_DATA | writing payload word i to the TX cache
// WR_PTR  | writing the message pointer register
// WR_SEND | writing the send register
// DONE    | one-cycle done pulse
// ERR     | one-cycle err pulse (bad length or bus error)
module endpoint_tx_host #(
  parameter int NUM_MSGS        = 4,
  parameter int CACHE_NUM_WORDS = 128
) (
  input logic               clk,
  input logic               rst,
  endpoint_tx_host_if.slave io
);
  localparam int MSG_W  = $clog2(NUM_MSGS);
  localparam int WORD_W = $clog2(CACHE_NUM_WORDS);
  localparam int LEN_W  = WORD_W + 1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(CACHE_NUM_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DATA = 3'd1;
  localparam logic [2:0] S_WR_PTR  = 3'd2;
  localparam logic [2:0] S_WR_SEND = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [2:0]        state;
  logic [MSG_W-1:0]  msg_id_q;
  logic [WORD_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  word_sum;
  logic [LEN_W-1:0]  word_idx;
  logic              wen;
  logic              complete;
  logic              unused_rdata;

  // start < DEPTH and idx < DEPTH, so one conditional subtract is a full modulo
  assign word_sum = {1'b0, start_q} + idx_q;
  assign word_idx = (word_sum >= DEPTH) ? word_sum - DEPTH : word_sum;

  assign complete = wen & ~io.bus_request_stall;

  // Bus fields are pure functions of state and latched fields, so they hold
  // on their own while the bus stalls.
  always_comb begin
    wen           = 1'b0;
    io.bus_addr   = '0;
    io.bus_wdata  = '0;
    io.bus_strobe = '0;
    io.data_ready = 1'b0;
    case (state)
      S_WR_DATA: begin
        wen           = io.data_valid;
        io.bus_addr   = 32'h2000 + (32'(word_idx) << 2);
        io.bus_wdata  = io.data_word;
        io.bus_strobe = 4'hF;
        io.data_ready = io.data_valid & ~io.bus_request_stall;
      end
      S_WR_PTR: begin
        wen           = 1'b1;
        io.bus_addr   = 32'(msg_id_q) << 2;
        io.bus_wdata  = 32'(start_q) << 2;
        io.bus_strobe = 4'hF;
      end
      S_WR_SEND: begin
        wen           = 1'b1;
        io.bus_addr   = 32'h1004;
        io.bus_wdata  = 32'(msg_id_q);
        io.bus_strobe = 4'hF;
      end
      default: ;
    endcase
  end

  assign io.bus_wen   = wen;
  assign io.bus_ren   = 1'b0;
  assign io.busy      = (state != S_IDLE);
  assign io.done      = (state == S_DONE);
  assign io.err       = (state == S_ERR);
  // held low while reset is applied even though the FSM already sits in IDLE
  assign io.cmd_ready = (state == S_IDLE) & ~rst;

  // read data is never used; this is a write-only initiator
  assign unused_rdata = ^io.bus_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      msg_id_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.cmd_valid) begin
            msg_id_q <= io.cmd_msg_id;
            start_q  <= io.cmd_start_word;
            len_q    <= io.cmd_len;
            idx_q    <= '0;
            if (io.cmd_len == '0 || io.cmd_len > DEPTH) state <= S_ERR;
            else                                        state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (complete) begin
            if (io.bus_error)                          state <= S_ERR;
            else if (idx_q == len_q - LEN_W'(1))       state <= S_WR_PTR;
            else                                       idx_q <= idx_q + LEN_W'(1);
          end
        end
        S_WR_PTR: begin
          if (complete) state <= io.bus_error ? S_ERR : S_WR_SEND;
        end
        S_WR_SEND: begin
          if (complete) state <= io.bus_error ? S_ERR : S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_endpoint_tx_host.sv
// Testbench for endpoint_tx_host: directed cases plus randomized commands
// with random data gaps, bus stalls and bus errors, checked against a
// transaction-level model (expected list of bus writes, done/err outcome,
// cycle latency).
module tb_endpoint_tx_host;
  localparam int NM = 4;
  localparam int CW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  endpoint_tx_host_if #(.NUM_MSGS(NM), .CACHE_NUM_WORDS(CW)) ifc ();

  endpoint_tx_host #(.NUM_MSGS(NM), .CACHE_NUM_WORDS(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // payload source: written by the stimulus, consumed by the responder
  logic [31:0] data_mem [0:4095];
  int data_wr = 0;
  int data_rd = 0;

  // responder configuration (stimulus-owned)
  int wbase     = 0;
  int stall_rel = -1;
  int stall_n   = 0;
  int err_rel   = -1;
  bit rand_stall = 1'b0;
  bit gap_en     = 1'b0;

  // monitor state (responder-owned)
  int wcount = 0, cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int ren_bad = 0, idle_bad = 0, hold_bad = 0, ready_bad = 0;
  int stalled_here = 0;
  bit hold_v = 1'b0, prev_stall = 1'b0, avail = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_strb = '0;
  logic [31:0] obs_addr [0:4095];
  logic [31:0] obs_data [0:4095];
  logic [3:0]  obs_strb [0:4095];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per cycle: drive payload, respond on the bus, then sample everything.
  always @(negedge clk) begin
    avail = (data_rd < data_wr);
    ifc.data_valid = avail && (hold_v || !gap_en || ($urandom_range(0, 2) != 0));
    ifc.data_word  = avail ? data_mem[data_rd] : 32'h0;
    #1;
    if (ifc.bus_wen && (wcount - wbase == stall_rel) && stalled_here < stall_n)
      ifc.bus_request_stall = 1'b1;
    else
      ifc.bus_request_stall = ifc.bus_wen && rand_stall && ($urandom_range(0, 3) == 0);
    ifc.bus_error = ifc.bus_wen && !ifc.bus_request_stall && (wcount - wbase == err_rel);
    #1;
    if (prev_stall && (ifc.bus_addr !== prev_addr || ifc.bus_wdata !== prev_wdata ||
                       ifc.bus_strobe !== prev_strb || ifc.bus_wen !== 1'b1))
      hold_bad++;
    prev_stall = ifc.bus_wen && ifc.bus_request_stall;
    prev_addr  = ifc.bus_addr;
    prev_wdata = ifc.bus_wdata;
    prev_strb  = ifc.bus_strobe;
    if (ifc.data_ready && (ifc.bus_request_stall || !ifc.data_valid)) ready_bad++;
    if (ifc.bus_ren !== 1'b0) ren_bad++;
    if ((!ifc.busy || ifc.done || ifc.err) &&
        (ifc.bus_wen || ifc.bus_addr != 0 || ifc.bus_wdata != 0 || ifc.bus_strobe != 0 || ifc.data_ready))
      idle_bad++;
    if (ifc.cmd_valid && ifc.cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (ifc.done) begin done_cnt++; done_cyc = cyc; end
    if (ifc.err)  begin err_cnt++;  err_cyc  = cyc; end
    if (ifc.data_ready) data_rd++;
    hold_v = ifc.data_valid && !ifc.data_ready;
    if (ifc.bus_wen && !ifc.bus_request_stall) begin
      obs_addr[wcount] = ifc.bus_addr;
      obs_data[wcount] = ifc.bus_wdata;
      obs_strb[wcount] = ifc.bus_strobe;
      wcount++;
      stalled_here = 0;
    end else if (ifc.bus_wen) begin
      stalled_here++;
    end
    cyc++;
  end

  task automatic issue_cmd(input int msg, input int start, input int len);
    int a0;
    a0 = acc_cnt;
    wbase = wcount;
    ifc.cmd_msg_id     = 2'(msg);
    ifc.cmd_start_word = 7'(start);
    ifc.cmd_len        = 8'(len);
    ifc.cmd_valid      = 1'b1;
    for (int t = 0; t < 20 && acc_cnt == a0; t++) begin
      @(posedge clk); #1;
    end
    ifc.cmd_valid = 1'b0;
    check("accept", 32'(acc_cnt - a0), 32'd1);
  endtask

  // Model: a command is the list of writes the spec demands, cut short after
  // the write that saw bus_error; latency counts one cycle per write plus stalls.
  task automatic run_cmd(input int msg, input int start, input int len,
                         input int s_rel, input int s_n, input int e_rel,
                         input bit rs, input bit gp, input bit chk_lat,
                         input logic [31:0] base_word, input string tag);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    bit valid_len, err_hit, exp_done;
    int d0, e0, nw, lat, adj;
    valid_len = (len >= 1 && len <= CW);
    if (valid_len) begin
      for (int k = 0; k < len; k++) begin
        data_mem[data_wr + k] = (base_word != 0) ? base_word + 32'(k) : $urandom;
        ea.push_back(32'(32'h2000 + 4 * ((start + k) % CW)));
        ed.push_back(data_mem[data_wr + k]);
      end
      data_wr += len;
      ea.push_back(32'(4 * msg));    ed.push_back(32'(4 * start));
      ea.push_back(32'h1004);        ed.push_back(32'(msg));
    end
    err_hit = valid_len && e_rel >= 0 && e_rel < ea.size();
    if (err_hit) while (ea.size() > e_rel + 1) begin void'(ea.pop_back()); void'(ed.pop_back()); end
    exp_done = valid_len && !err_hit;

    stall_rel = s_rel; stall_n = s_n; err_rel = e_rel; rand_stall = rs; gap_en = gp;
    d0 = done_cnt; e0 = err_cnt;
    issue_cmd(msg, start, len);
    for (int t = 0; t < 3000 && done_cnt == d0 && err_cnt == e0; t++) begin
      @(posedge clk); #1;
    end
    check({tag, ":done"}, 32'(done_cnt - d0), 32'(exp_done));
    check({tag, ":err"},  32'(err_cnt - e0),  32'(!exp_done));
    check({tag, ":idle_ready"}, 32'(ifc.cmd_ready), 32'd1);
    nw = wcount - wbase;
    check({tag, ":nwrites"}, 32'(nw), 32'(ea.size()));
    for (int k = 0; k < ea.size() && k < nw; k++) begin
      check($sformatf("%s:addr%0d", tag, k), obs_addr[wbase + k], ea[k]);
      check($sformatf("%s:data%0d", tag, k), obs_data[wbase + k], ed[k]);
      check($sformatf("%s:strb%0d", tag, k), 32'(obs_strb[wbase + k]), 32'hF);
    end
    if (chk_lat) begin
      adj = (s_rel >= 0 && (exp_done || s_rel <= e_rel)) ? s_n : 0;
      if (exp_done)       lat = len + 3 + adj;
      else if (!valid_len) lat = 1;
      else                lat = e_rel + 2 + adj;
      check({tag, ":latency"}, 32'(exp_done ? done_cyc - acc_cyc : err_cyc - acc_cyc), 32'(lat));
    end
    data_wr = data_rd;
    stall_rel = -1; stall_n = 0; err_rel = -1; rand_stall = 1'b0; gap_en = 1'b0;
  endtask

  initial begin
    int msg, start, len, sel, e;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_msg_id = '0;
    ifc.cmd_start_word = '0;
    ifc.cmd_len = '0;
    ifc.bus_rdata = 32'hDEAD_BEEF;
    ifc.data_valid = 1'b0;
    ifc.data_word = '0;
    ifc.bus_error = 1'b0;
    ifc.bus_request_stall = 1'b0;

    // reset values
    @(negedge clk); #3;
    check("rst:cmd_ready", 32'(ifc.cmd_ready), 32'd0);
    check("rst:busy",      32'(ifc.busy),      32'd0);
    check("rst:bus_wen",   32'(ifc.bus_wen),   32'd0);
    check("rst:data_rdy",  32'(ifc.data_ready), 32'd0);
    check("rst:done_err",  32'({ifc.done, ifc.err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel:cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    @(posedge clk); #1;

    // directed
    run_cmd(1, 0, 3, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0000_000A, "basic");
    run_cmd(2, 126, 4, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, "wrap");
    run_cmd(3, 5, 3, 1, 3, -1, 1'b0, 1'b0, 1'b1, 32'h0, "stall");
    run_cmd(0, 0, 0, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, "len0");
    run_cmd(1, 0, 129, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, "len129");
    run_cmd(2, 7, 3, -1, 0, 4, 1'b0, 1'b0, 1'b1, 32'h0, "err_send");
    run_cmd(1, 20, 4, -1, 0, 1, 1'b0, 1'b0, 1'b1, 32'h0, "err_data");
    run_cmd(3, 127, 128, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, "full");

    // reset in the middle of a command
    for (int k = 0; k < 5; k++) data_mem[data_wr + k] = $urandom;
    data_wr += 5;
    issue_cmd(2, 10, 5);
    for (int t = 0; t < 50 && (wcount - wbase) < 2; t++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst:wen",   32'(ifc.bus_wen),    32'd0);
    check("mid_rst:addr",  ifc.bus_addr,        32'd0);
    check("mid_rst:wdata", ifc.bus_wdata,       32'd0);
    check("mid_rst:strb",  32'(ifc.bus_strobe), 32'd0);
    check("mid_rst:stat",  32'({ifc.busy, ifc.done, ifc.err, ifc.data_ready, ifc.cmd_ready}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    data_wr = data_rd;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst:nwrites", 32'(wcount - wbase), 32'd2);
    check("post_rst:ready",   32'(ifc.cmd_ready),  32'd1);
    check("post_rst:busy",    32'(ifc.busy),       32'd0);
    run_cmd(1, 40, 2, -1, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, "after_rst");

    // randomized commands with data gaps, random stalls and occasional errors
    for (int n = 0; n < 20; n++) begin
      msg   = $urandom_range(0, NM - 1);
      start = $urandom_range(0, CW - 1);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(CW + 1, 255);
      else if (sel == 1) len = CW;
      else               len = $urandom_range(1, 12);
      e = -1;
      if (len >= 1 && len <= CW && $urandom_range(0, 4) == 0) e = $urandom_range(0, len + 1);
      run_cmd(msg, start, len, -1, 0, e, 1'b1, 1'b1, 1'b0, 32'h0, $sformatf("rnd%0d", n));
    end

    check("inv:ren",   32'(ren_bad),   32'd0);
    check("inv:idle",  32'(idle_bad),  32'd0);
    check("inv:hold",  32'(hold_bad),  32'd0);
    check("inv:ready", 32'(ready_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
